// File: rtl/csa_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
// Geometry check and stage count derivation live here so every user agrees.
package csa_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefBlk   = 4;

  function automatic int unsigned calc_nblk(input int unsigned width, input int unsigned blk);
    return width / blk;
  endfunction

  function automatic bit geom_ok(input int unsigned width, input int unsigned blk);
    return (blk != 0) && (width >= blk) && ((width % blk) == 0);
  endfunction

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/csa_pipe_adder_block.sv
// Combinational BLK-bit carry-select cell: two ripple sums (cin=0 / cin=1) and a mux.
// c_msb is the carry into the top bit, needed for signed overflow.
module csa_block
  import csa_pkg::*;
#(
  parameter int unsigned BLK = DefBlk
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  logic [BLK-1:0] sum0, sum1;
  logic           rc0, rc1, cm0, cm1;

  always_comb begin
    sum0 = '0;
    sum1 = '0;
    rc0  = 1'b0;
    rc1  = 1'b1;
    cm0  = 1'b0;
    cm1  = 1'b0;
    for (int i = 0; i < int'(BLK); i++) begin
      if (i == int'(BLK) - 1) begin
        cm0 = rc0;
        cm1 = rc1;
      end
      sum0[i] = a[i] ^ b[i] ^ rc0;
      sum1[i] = a[i] ^ b[i] ^ rc1;
      rc0     = maj(a[i], b[i], rc0);
      rc1     = maj(a[i], b[i], rc1);
    end
  end

  assign sum   = cin ? sum1 : sum0;
  assign cout  = cin ? rc1  : rc0;
  assign c_msb = cin ? cm1  : cm0;

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor: one BLK-bit block resolved per stage,
// valid/ready on both sides, bubbles collapse, full throughput.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned BLK   = DefBlk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NBLK = calc_nblk(WIDTH, BLK);

  if (!geom_ok(WIDTH, BLK)) begin : g_bad_geom
    $error("csa_pipe_adder: WIDTH must be a non-zero multiple of BLK");
  end

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [NBLK-1:0]  valid;
  logic [NBLK-1:0]  load;

  assign b_eff = in_sub ? ~in_b : in_b;
  assign c0    = in_sub ? 1'b1 : in_cin;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    load           = '0;
    load[NBLK-1]   = !valid[NBLK-1] || out_ready;
    for (int k = int'(NBLK) - 2; k >= 0; k--) begin
      load[k] = !valid[k] || load[k+1];
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in, s_nx;
    logic             c_in, v_in;
    logic [BLK-1:0]   blk_sum;
    logic             blk_co, blk_cm;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_q, ovf_q, v_q;
    logic             unused_stage;

    if (k == 0) begin : g_head
      assign a_in = in_a;
      assign b_in = b_eff;
      assign s_in = '0;
      assign c_in = c0;
      assign v_in = in_valid;
    end else begin : g_body
      assign a_in = g_stage[k-1].a_q;
      assign b_in = g_stage[k-1].b_q;
      assign s_in = g_stage[k-1].s_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
    end

    csa_block #(
      .BLK(BLK)
    ) u_block (
      .a    (a_in[k*BLK +: BLK]),
      .b    (b_in[k*BLK +: BLK]),
      .cin  (c_in),
      .sum  (blk_sum),
      .cout (blk_co),
      .c_msb(blk_cm)
    );

    always_comb begin
      s_nx                 = s_in;
      s_nx[k*BLK +: BLK]   = blk_sum;
    end

    // Data only moves with a real beat so a stalled or emptied stage keeps its contents.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        s_q   <= '0;
        c_q   <= 1'b0;
        ovf_q <= 1'b0;
      end else if (load[k]) begin
        v_q <= v_in;
        if (v_in) begin
          a_q   <= a_in;
          b_q   <= b_in;
          s_q   <= s_nx;
          c_q   <= blk_co;
          ovf_q <= blk_co ^ blk_cm;
        end
      end
    end

    assign valid[k] = v_q;

    // Operand copies in the last stage and ovf_q in inner stages have no consumer.
    assign unused_stage = ^{a_q, b_q, ovf_q};
  end

  assign out_valid = g_stage[NBLK-1].v_q;
  assign out_sum   = g_stage[NBLK-1].s_q;
  assign out_co    = g_stage[NBLK-1].c_q;
  assign out_ovf   = g_stage[NBLK-1].ovf_q;
  assign out_zero  = out_valid && (out_sum == '0);

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench: four geometries driven in lockstep, scoreboarded against an
// arithmetic model, plus literal directed cases, streaming, back-pressure and reset.
module tb_csa_pipe_adder;

  localparam int NI = 4;
  localparam int WID [NI] = '{16, 8, 32, 4};
  localparam int NBK [NI] = '{4, 4, 4, 1};

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
    logic        zero;
    int          ca;
  } exp_t;

  logic        clk;
  logic        rst_n, in_valid, out_ready, in_cin, in_sub;
  logic [31:0] in_a, in_b;

  logic        rdy   [NI];
  logic        ov    [NI];
  logic [31:0] osum  [NI];
  logic        oco   [NI];
  logic        oovf  [NI];
  logic        ozero [NI];

  logic [15:0] s0;
  logic [7:0]  s1;
  logic [31:0] s2;
  logic [3:0]  s3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_low = -1;

  exp_t        scb  [NI][64];
  int          head [NI];
  int          tail [NI];
  logic        hold [NI];
  logic [31:0] hsum [NI];
  logic        hco  [NI];
  logic        hovf [NI];

  csa_pipe_adder #(.WIDTH(16), .BLK(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov[0]), .out_ready(out_ready), .out_sum(s0), .out_co(oco[0]),
    .out_ovf(oovf[0]), .out_zero(ozero[0])
  );
  csa_pipe_adder #(.WIDTH(8), .BLK(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov[1]), .out_ready(out_ready), .out_sum(s1), .out_co(oco[1]),
    .out_ovf(oovf[1]), .out_zero(ozero[1])
  );
  csa_pipe_adder #(.WIDTH(32), .BLK(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov[2]), .out_ready(out_ready), .out_sum(s2), .out_co(oco[2]),
    .out_ovf(oovf[2]), .out_zero(ozero[2])
  );
  csa_pipe_adder #(.WIDTH(4), .BLK(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov[3]), .out_ready(out_ready), .out_sum(s3), .out_co(oco[3]),
    .out_ovf(oovf[3]), .out_zero(ozero[3])
  );

  assign osum[0] = {16'h0, s0};
  assign osum[1] = {24'h0, s1};
  assign osum[2] = s2;
  assign osum[3] = {28'h0, s3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic; overflow from operand/result signs.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input int w);
    exp_t        r;
    logic [63:0] mask, av, bx, full;
    logic        sa, sbx, ss;
    mask   = (64'd1 << w) - 64'd1;
    av     = {32'h0, a} & mask;
    bx     = sub ? (~{32'h0, b}) & mask : {32'h0, b} & mask;
    full   = av + bx + (sub ? 64'd1 : {63'd0, cin});
    r.sum  = full[31:0] & mask[31:0];
    r.co   = full[w];
    sa     = av[w-1];
    sbx    = bx[w-1];
    ss     = full[w-1];
    r.ovf  = (sa == sbx) && (ss != sa);
    r.zero = (r.sum == 32'h0);
    r.ca   = 0;
    return r;
  endfunction

  // Scoreboard / compare process, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!out_ready) last_low = cyc;
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          head[i] = 0;
          tail[i] = 0;
          hold[i] = 1'b0;
        end else begin
          if (hold[i]) begin
            chk($sformatf("i%0d stall valid", i), 32'(ov[i]), 32'd1);
            chk($sformatf("i%0d stall sum", i), osum[i], hsum[i]);
            chk($sformatf("i%0d stall co", i), 32'(oco[i]), 32'(hco[i]));
            chk($sformatf("i%0d stall ovf", i), 32'(oovf[i]), 32'(hovf[i]));
          end
          hold[i] = ov[i] && !out_ready;
          hsum[i] = osum[i];
          hco[i]  = oco[i];
          hovf[i] = oovf[i];
          if (ov[i] && out_ready) begin
            if (head[i] == tail[i]) begin
              checks++;
              errors++;
              $display("FAIL i%0d unexpected beat: got out_valid=1 sum=0x%0h, expected no beat",
                       i, osum[i]);
            end else begin
              e = scb[i][head[i] % 64];
              head[i]++;
              chk($sformatf("i%0d sum", i), osum[i], e.sum);
              chk($sformatf("i%0d co", i), 32'(oco[i]), 32'(e.co));
              chk($sformatf("i%0d ovf", i), 32'(oovf[i]), 32'(e.ovf));
              chk($sformatf("i%0d zero", i), 32'(ozero[i]), 32'(e.zero));
              if (last_low < e.ca) chk($sformatf("i%0d latency", i), 32'(cyc - e.ca), 32'(NBK[i]));
            end
          end
          if (in_valid && rdy[i]) begin
            e = model(in_a, in_b, in_cin, in_sub, WID[i]);
            e.ca = cyc;
            scb[i][tail[i] % 64] = e;
            tail[i]++;
          end
        end
      end
    end
  end

  task automatic rand_ops();
    in_a   = $urandom;
    in_b   = ($urandom_range(7) == 0) ? in_a : $urandom;
    in_cin = 1'($urandom_range(1));
    in_sub = 1'($urandom_range(1));
  endtask

  task automatic cycle_drive(input logic v, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = r;
    rand_ops();
  endtask

  task automatic dir_test(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] es,
                          input logic eco, input logic eovf, input logic ez);
    int          lat;
    logic [31:0] gs;
    logic        gco, govf, gz;
    lat = 0;
    gs  = 'x;
    gco = 1'bx;
    govf = 1'bx;
    gz  = 1'bx;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_a      = {16'h0, a};
    in_b      = {16'h0, b};
    in_cin    = cin;
    in_sub    = sub;
    @(negedge clk);
    chk({nm, " accept"}, 32'(rdy[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ov[0]) begin
        lat  = k;
        gs   = osum[0];
        gco  = oco[0];
        govf = oovf[0];
        gz   = ozero[0];
        break;
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'd4);
    chk({nm, " sum"}, gs, {16'h0, es});
    chk({nm, " co"}, 32'(gco), 32'(eco));
    chk({nm, " ovf"}, 32'(govf), 32'(eovf));
    chk({nm, " zero"}, 32'(gz), 32'(ez));
  endtask

  initial begin
    logic [11:0] hist;
    logic [4:0]  rh0, rh3;
    int          nval;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", 32'(ov[0]), 32'd0);
    chk("reset out_sum", osum[0], 32'h0);
    chk("reset out_co", 32'(oco[0]), 32'd0);
    chk("reset out_ovf", 32'(oovf[0]), 32'd0);
    chk("reset out_zero", 32'(ozero[0]), 32'd0);
    chk("reset in_ready", 32'(rdy[0]), 32'd1);

    dir_test("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    dir_test("carry", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir_test("sub borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    dir_test("sub ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Eight back-to-back beats must emerge on eight consecutive cycles.
    hist = '0;
    for (int i = 0; i < 12; i++) begin
      cycle_drive(i < 8, 1'b1);
      @(negedge clk);
      hist[i] = ov[0];
    end
    chk("stream out_valid pattern", 32'(hist), 32'h0FF0);

    // Back-pressure from an empty pipe while feeding every cycle.
    rh0 = '0;
    rh3 = '0;
    for (int i = 0; i < 5; i++) begin
      cycle_drive(1'b1, 1'b0);
      @(negedge clk);
      rh0[i] = rdy[0];
      rh3[i] = rdy[3];
    end
    chk("bp in_ready 4-stage", 32'(rh0), 32'h0F);
    chk("bp in_ready 1-stage", 32'(rh3), 32'h01);
    chk("bp out_valid held", 32'(ov[0]), 32'd1);
    cycle_drive(1'b0, 1'b1);
    repeat (8) @(negedge clk);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      cycle_drive(1'b1, 1'b1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("i%0d valid after reset", i), 32'(ov[i]), 32'd0);
    chk("in_ready after reset", 32'(rdy[0]), 32'd1);
    nval = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov[0]) nval++;
    end
    chk("stale beats after reset", 32'(nval), 32'd0);

    repeat (300) cycle_drive($urandom_range(9) < 7, $urandom_range(9) < 6);
    repeat (300) cycle_drive($urandom_range(9) < 8, 1'b1);
    cycle_drive(1'b0, 1'b1);
    repeat (12) @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("i%0d beats left", i), 32'(tail[i] - head[i]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
